// File: rtl/nav_integrator_if.sv
// Jump request channel between the helm logic (master) and nav_integrator (slave).
// Carries the valid/ready handshake, the per-axis destination and the abort request.
interface nav_integrator_if #(
  parameter int K    = 16,
  parameter int AXES = 3
);
  logic              jump_valid;
  logic              jump_ready;
  logic [AXES*K-1:0] jump_target;
  logic              abort;

  modport master (output jump_valid, output jump_target, output abort, input jump_ready);
  modport slave  (input jump_valid, input jump_target, input abort, output jump_ready);
endinterface

// File: rtl/nav_integrator.sv
// Multi-axis saturating position integrator with mode-scaled velocity and a
// charge/cool jump sequencer driven by a valid/ready request channel.
module nav_integrator #(
  parameter int K             = 16,
  parameter int AXES          = 3,
  parameter int CHARGE_CYCLES = 4,
  parameter int COOL_CYCLES   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          mode,
  input  logic [AXES*K-1:0]   speed,
  input  logic                zero_pos,
  nav_integrator_if.slave     jump,
  output logic [AXES*K-1:0]   pos,
  output logic [AXES-1:0]     sat,
  output logic                mode_err,
  output logic [1:0]          state,
  output logic                busy
);

  localparam logic [1:0] ST_CRUISE = 2'b00;
  localparam logic [1:0] ST_CHARGE = 2'b01;
  localparam logic [1:0] ST_COOL   = 2'b10;

  localparam int CNT_MAX  = (CHARGE_CYCLES > COOL_CYCLES) ? CHARGE_CYCLES : COOL_CYCLES;
  localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CHARGE_LOAD = CNT_W'(CHARGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD   = CNT_W'((COOL_CYCLES > 0) ? COOL_CYCLES - 1 : 0);

  logic [CNT_W-1:0]  cnt;
  logic [AXES*K-1:0] target;
  logic [AXES*K-1:0] int_pos;
  logic [AXES-1:0]   int_sat;
  logic              vel_en;
  logic [1:0]        shamt;
  logic              mode_bad;
  logic              accept;

  // Handshake status depends on state alone, so there is no input-to-output path.
  assign jump.jump_ready = (state == ST_CRUISE);
  assign busy            = (state != ST_CRUISE);
  assign accept          = jump.jump_valid && jump.jump_ready;

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    vel_en   = 1'b0;
    shamt    = 2'd0;
    mode_bad = 1'b0;
    unique case (mode)
      4'b0001: vel_en = 1'b0;
      4'b0010: begin vel_en = 1'b1; shamt = 2'd0; end
      4'b0100: begin vel_en = 1'b1; shamt = 2'd1; end
      4'b1000: begin vel_en = 1'b1; shamt = 2'd2; end
      default: mode_bad = 1'b1;
    endcase
  end

  for (genvar i = 0; i < AXES; i++) begin : g_axis
    logic signed [K-1:0] spd;
    logic signed [K-1:0] shifted;
    logic signed [K-1:0] vel;
    logic signed [K-1:0] cur;
    logic signed [K:0]   sum;
    logic                ovf;

    assign spd = speed[i*K +: K];
    assign cur = pos[i*K +: K];
    // Kept as its own signed expression so >>> stays arithmetic (floor toward -inf).
    assign shifted = spd >>> shamt;
    assign vel     = vel_en ? shifted : '0;
    assign sum     = {cur[K-1], cur} + {vel[K-1], vel};
    assign ovf     = sum[K] ^ sum[K-1];

    assign int_pos[i*K +: K] = !ovf    ? sum[K-1:0] :
                               sum[K]  ? {1'b1, {(K-1){1'b0}}} :
                                         {1'b0, {(K-1){1'b1}}};
    assign int_sat[i] = ovf;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos      <= '0;
      sat      <= '0;
      mode_err <= 1'b0;
      state    <= ST_CRUISE;
      cnt      <= '0;
      target   <= '0;
    end else begin
      mode_err <= mode_bad;
      if (zero_pos) begin
        pos    <= '0;
        sat    <= '0;
        state  <= ST_CRUISE;
        cnt    <= '0;
        target <= '0;
      end else begin
        unique case (state)
          ST_CRUISE: begin
            pos <= int_pos;
            sat <= int_sat;
            if (accept) begin
              target <= jump.jump_target;
              cnt    <= CHARGE_LOAD;
              state  <= ST_CHARGE;
            end
          end
          ST_CHARGE: begin
            if (jump.abort) begin
              state  <= ST_CRUISE;
              cnt    <= '0;
              target <= '0;
            end else if (cnt == '0) begin
              pos   <= target;
              sat   <= '0;
              cnt   <= COOL_LOAD;
              state <= (COOL_CYCLES == 0) ? ST_CRUISE : ST_COOL;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ST_COOL: begin
            if (cnt == '0) state <= ST_CRUISE;
            else           cnt   <= cnt - 1'b1;
          end
          default: begin
            state <= ST_CRUISE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nav_integrator.sv
// Directed bench for nav_integrator (K=16, AXES=3, CHARGE=4, COOL=2) with
// hand-computed expectations; speed/pos pack X in the MSBs.
module tb_nav_integrator;

  localparam int K    = 16;
  localparam int AXES = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        mode;
  logic [AXES*K-1:0] speed;
  logic              zero_pos;
  logic [AXES*K-1:0] pos;
  logic [AXES-1:0]   sat;
  logic              mode_err;
  logic [1:0]        state;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  nav_integrator_if #(.K(K), .AXES(AXES)) jif ();

  nav_integrator #(.K(K), .AXES(AXES), .CHARGE_CYCLES(4), .COOL_CYCLES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .speed    (speed),
    .zero_pos (zero_pos),
    .jump     (jif),
    .pos      (pos),
    .sat      (sat),
    .mode_err (mode_err),
    .state    (state),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] p3(input int x, input int y, input int z);
    logic [15:0] xs, ys, zs;
    xs = x[15:0];
    ys = y[15:0];
    zs = z[15:0];
    return {xs, ys, zs};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_zero();
    zero_pos = 1'b1;
    step(1);
    zero_pos = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    mode            = 4'b0001;
    speed           = '0;
    zero_pos        = 1'b0;
    jif.jump_valid  = 1'b0;
    jif.jump_target = '0;
    jif.abort       = 1'b0;
    #12;
    check("rst_pos",      64'(pos), 64'd0);
    check("rst_sat",      64'(sat), 64'd0);
    check("rst_mode_err", 64'(mode_err), 64'd0);
    check("rst_state",    64'(state), 64'd0);
    check("rst_busy",     64'(busy), 64'd0);
    check("rst_ready",    64'(jif.jump_ready), 64'd1);
    rst_n = 1'b1;

    // Attack mode, 4 cycles.
    mode  = 4'b0010;
    speed = p3(5, -3, 0);
    step(4);
    check("attack_pos", 64'(pos), 64'(p3(20, -12, 0)));
    check("attack_sat", 64'(sat), 64'd0);

    // Stealth: -7 >>> 2 = -2 per cycle.
    do_zero();
    mode  = 4'b1000;
    speed = p3(-7, 0, 0);
    step(2);
    check("stealth_pos", 64'(pos), 64'(p3(-4, 0, 0)));
    mode = 4'b0110;
    step(1);
    check("badmode_pos", 64'(pos), 64'(p3(-4, 0, 0)));
    check("badmode_err", 64'(mode_err), 64'd1);
    mode = 4'b0100;
    speed = p3(7, -7, 1);
    step(1);
    check("defense_pos", 64'(pos), 64'(p3(-1, -4, 0)));
    check("defense_err", 64'(mode_err), 64'd0);

    // Positive clamp then recovery.
    do_zero();
    mode  = 4'b0010;
    speed = p3(16380, 0, 0);
    step(2);
    check("pre_clamp", 64'(pos), 64'(p3(32760, 0, 0)));
    speed = p3(100, 0, 0);
    step(1);
    check("clamp_pos", 64'(pos), 64'(p3(32767, 0, 0)));
    check("clamp_sat", 64'(sat), 64'b100);
    speed = p3(-1, 0, 0);
    step(1);
    check("unclamp_pos", 64'(pos), 64'(p3(32766, 0, 0)));
    check("unclamp_sat", 64'(sat), 64'd0);

    // Negative clamp on Y.
    do_zero();
    speed = p3(0, -32768, 0);
    step(2);
    check("negclamp_pos", 64'(pos), 64'(p3(0, -32768, 0)));
    check("negclamp_sat", 64'(sat), 64'b010);

    // Full jump; valid held high throughout, including COOL.
    do_zero();
    speed           = p3(1, 2, 3);
    jif.jump_valid  = 1'b1;
    jif.jump_target = p3(1000, -1000, 7);
    step(1);  // t0: accept, integration still applies
    check("acc_pos",   64'(pos), 64'(p3(1, 2, 3)));
    check("acc_state", 64'(state), 64'd1);
    check("acc_ready", 64'(jif.jump_ready), 64'd0);
    check("acc_busy",  64'(busy), 64'd1);
    jif.jump_target = p3(55, 55, 55);
    step(3);  // t0+3
    check("chg_pos",   64'(pos), 64'(p3(1, 2, 3)));
    check("chg_state", 64'(state), 64'd1);
    step(1);  // t0+4: land
    check("land_pos",   64'(pos), 64'(p3(1000, -1000, 7)));
    check("land_state", 64'(state), 64'd2);
    check("land_sat",   64'(sat), 64'd0);
    step(1);  // t0+5
    check("cool_state", 64'(state), 64'd2);
    check("cool_ready", 64'(jif.jump_ready), 64'd0);
    check("cool_pos",   64'(pos), 64'(p3(1000, -1000, 7)));
    step(1);  // t0+6
    check("ret_state", 64'(state), 64'd0);
    check("ret_ready", 64'(jif.jump_ready), 64'd1);
    check("ret_pos",   64'(pos), 64'(p3(1000, -1000, 7)));
    jif.jump_valid = 1'b0;
    step(1);
    check("post_pos",   64'(pos), 64'(p3(1001, -998, 10)));
    check("post_state", 64'(state), 64'd0);

    // Abort on the second CHARGE cycle.
    do_zero();
    speed           = p3(1, 1, 1);
    jif.jump_valid  = 1'b1;
    jif.jump_target = p3(500, 500, 500);
    step(1);
    jif.jump_valid = 1'b0;
    check("ab_acc_pos", 64'(pos), 64'(p3(1, 1, 1)));
    step(1);
    jif.abort = 1'b1;
    step(1);
    jif.abort = 1'b0;
    check("ab_state", 64'(state), 64'd0);
    check("ab_pos",   64'(pos), 64'(p3(1, 1, 1)));
    step(4);
    check("ab_resume", 64'(pos), 64'(p3(5, 5, 5)));

    // zero_pos in COOL wins over abort and jump_valid.
    jif.jump_valid  = 1'b1;
    jif.jump_target = p3(9, 9, 9);
    step(1);
    jif.jump_valid = 1'b0;
    step(4);
    check("z_cool_state", 64'(state), 64'd2);
    check("z_cool_pos",   64'(pos), 64'(p3(9, 9, 9)));
    zero_pos       = 1'b1;
    jif.abort      = 1'b1;
    jif.jump_valid = 1'b1;
    step(1);
    zero_pos       = 1'b0;
    jif.abort      = 1'b0;
    jif.jump_valid = 1'b0;
    check("z_pos",   64'(pos), 64'd0);
    check("z_state", 64'(state), 64'd0);
    check("z_sat",   64'(sat), 64'd0);

    // Asynchronous reset mid-CHARGE.
    jif.jump_valid  = 1'b1;
    jif.jump_target = p3(77, 77, 77);
    step(1);
    jif.jump_valid = 1'b0;
    step(1);
    check("pre_rst_state", 64'(state), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_state", 64'(state), 64'd0);
    check("arst_pos",   64'(pos), 64'd0);
    check("arst_busy",  64'(busy), 64'd0);
    check("arst_ready", 64'(jif.jump_ready), 64'd1);
    rst_n = 1'b1;
    step(1);
    check("after_rst_pos", 64'(pos), 64'(p3(1, 1, 1)));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
